// File: rtl/mult_arbiter.sv
// Two-port round-robin arbiter in front of one shared 8x8 multiplier.
// All state advances only on clk edges where clk_half is low.
module mult_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_half,
    input  logic        req0_ld,
    input  logic        req1_ld,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req0_ok,
    output logic        req1_ok,
    output logic [15:0] req0_res,
    output logic [15:0] req1_res,
    output logic        mult_ld,
    output logic [7:0]  mult1,
    output logic [7:0]  mult2,
    input  logic        mult_ok,
    input  logic [15:0] mult_res,
    output logic [1:0]  grant,
    output logic        timeout_err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_REL  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic        mult_ld_q, mult_ld_d;
    logic [7:0]  mult1_q, mult1_d;
    logic [7:0]  mult2_q, mult2_d;
    logic        req0_ok_q, req0_ok_d;
    logic        req1_ok_q, req1_ok_d;
    logic [15:0] req0_res_q, req0_res_d;
    logic [15:0] req1_res_q, req1_res_d;
    logic [7:0]  timer_q, timer_d;
    logic        timeout_err_q, timeout_err_d;
    logic        en;
    logic        owner_ld;
    logic        pick1;

    assign en = ~clk_half;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        mult_ld_d     = mult_ld_q;
        mult1_d       = mult1_q;
        mult2_d       = mult2_q;
        req0_ok_d     = req0_ok_q;
        req1_ok_d     = req1_ok_q;
        req0_res_d    = req0_res_q;
        req1_res_d    = req1_res_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        owner_ld      = grant_q[1] ? req1_ld : req0_ld;
        // last_q==1 means req1 was served last, so req0 has priority on a tie.
        pick1         = req1_ld && (!req0_ld || !last_q);

        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!mult_ok && (req0_ld || req1_ld)) begin
                        grant_d = pick1 ? 2'b10 : 2'b01;
                        mult1_d = pick1 ? req1_a : req0_a;
                        mult2_d = pick1 ? req1_b : req0_b;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    mult_ld_d = 1'b1;
                    timer_d   = 8'd0;
                    state_d   = S_WAIT;
                end
                S_WAIT: begin
                    if (mult_ok) begin
                        mult_ld_d = 1'b0;
                        if (owner_ld) begin
                            if (grant_q[1]) begin
                                req1_res_d = mult_res;
                                req1_ok_d  = 1'b1;
                            end else begin
                                req0_res_d = mult_res;
                                req0_ok_d  = 1'b1;
                            end
                            state_d = S_DONE;
                        end else begin
                            state_d = S_REL;
                        end
                    end else if (timer_q == TIMEOUT - 8'd1) begin
                        timeout_err_d = 1'b1;
                        mult_ld_d     = 1'b0;
                        state_d       = S_REL;
                    end else if (timer_q != 8'hFF) begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (!owner_ld) begin
                        req0_ok_d = 1'b0;
                        req1_ok_d = 1'b0;
                        state_d   = S_REL;
                    end
                end
                S_REL: begin
                    // Hold ownership until the multiplier has dropped its done flag.
                    if (!mult_ok) begin
                        grant_d = 2'b00;
                        last_d  = grant_q[1];
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            grant_q       <= 2'b00;
            last_q        <= 1'b1;
            mult_ld_q     <= 1'b0;
            mult1_q       <= 8'h00;
            mult2_q       <= 8'h00;
            req0_ok_q     <= 1'b0;
            req1_ok_q     <= 1'b0;
            req0_res_q    <= 16'h0000;
            req1_res_q    <= 16'h0000;
            timer_q       <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            mult_ld_q     <= mult_ld_d;
            mult1_q       <= mult1_d;
            mult2_q       <= mult2_d;
            req0_ok_q     <= req0_ok_d;
            req1_ok_q     <= req1_ok_d;
            req0_res_q    <= req0_res_d;
            req1_res_q    <= req1_res_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req0_ok     = req0_ok_q;
    assign req1_ok     = req1_ok_q;
    assign req0_res    = req0_res_q;
    assign req1_res    = req1_res_q;
    assign mult_ld     = mult_ld_q;
    assign mult1       = mult1_q;
    assign mult2       = mult2_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, requester drivers, and a
// per-port expected-result scoreboard checked by an independent monitor.
module tb_mult_arbiter;

    localparam logic [7:0] TMO = 8'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_half = 1'b0;
    logic        req_ld [2];
    logic [7:0]  req_a [2];
    logic [7:0]  req_b [2];
    logic        req0_ok, req1_ok;
    logic [15:0] req0_res, req1_res;
    logic        mult_ld;
    logic [7:0]  mult1, mult2;
    logic        model_ok = 1'b0;
    logic        force_ok = 1'b0;
    logic        mult_ok;
    logic [15:0] mult_res = 16'h0;
    logic [1:0]  grant;
    logic        timeout_err;
    logic [2:0]  dbg_state;

    assign mult_ok = model_ok | force_ok;

    mult_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .clk_half(clk_half),
        .req0_ld(req_ld[0]), .req1_ld(req_ld[1]),
        .req0_a(req_a[0]), .req0_b(req_b[0]), .req1_a(req_a[1]), .req1_b(req_b[1]),
        .req0_ok(req0_ok), .req1_ok(req1_ok), .req0_res(req0_res), .req1_res(req1_res),
        .mult_ld(mult_ld), .mult1(mult1), .mult2(mult2),
        .mult_ok(mult_ok), .mult_res(mult_res),
        .grant(grant), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / clk_half ----------------
    always #5 clk = ~clk;

    int half_mode = 0;   // 0: always enabled, 1: toggle, 2: held high
    logic half_at_edge = 1'b0;
    always @(posedge clk) half_at_edge = clk_half;

    initial begin
        forever begin
            @(negedge clk);
            case (half_mode)
                1:       clk_half = ~clk_half;
                2:       clk_half = 1'b1;
                default: clk_half = 1'b0;
            endcase
        end
    end

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int grant_log[$];
    int rr_last = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_ok(input int p);
        return (p == 0) ? req0_ok : req1_ok;
    endfunction

    // ---------------- multiplier model ----------------
    int mdl_delay = 4;
    bit mdl_never = 0;
    int mdl_cnt = -1;
    logic mdl_prev_ld = 1'b0;
    int ld_high_edges = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!half_at_edge && mdl_prev_ld) ld_high_edges++;
            if (!mult_ld) begin
                model_ok = 1'b0;
                mdl_cnt  = -1;
            end else if (!mdl_prev_ld) begin
                mult_res = mult1 * mult2;
                mdl_cnt  = mdl_delay;
            end else if (!half_at_edge && mdl_cnt > 0) begin
                mdl_cnt--;
            end
            if (mult_ld && mdl_cnt == 0 && !mdl_never) model_ok = 1'b1;
            mdl_prev_ld = mult_ld;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_ok [2];
    logic [15:0] prev_res [2];
    logic [1:0]  prev_grant = 2'b00;

    initial begin
        prev_ok[0] = 1'b0; prev_ok[1] = 1'b0;
        prev_res[0] = 16'h0; prev_res[1] = 16'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_ok[0] = 1'b0; prev_ok[1] = 1'b0;
                prev_res[0] = 16'h0; prev_res[1] = 16'h0;
                prev_grant = 2'b00;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    logic        okv;
                    logic [15:0] resv;
                    logic [15:0] e;
                    okv  = get_ok(p);
                    resv = (p == 0) ? req0_res : req1_res;
                    if (okv && !prev_ok[p]) begin
                        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                            check($sformatf("unexpected_ok%0d", p), 64'(okv), 64'd0);
                        end else begin
                            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            check($sformatf("res%0d", p), 64'(resv), 64'(e));
                        end
                        check($sformatf("ok%0d_grant", p), 64'(grant), (p == 0) ? 64'd1 : 64'd2);
                    end else if (resv !== prev_res[p]) begin
                        check($sformatf("res%0d_stable", p), 64'(resv), 64'(prev_res[p]));
                    end
                    prev_ok[p]  = okv;
                    prev_res[p] = resv;
                end
                if (prev_grant == 2'b00 && grant != 2'b00) grant_log.push_back((grant == 2'b10) ? 1 : 0);
                prev_grant = grant;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic step();
        bit e;
        int n = 0;
        do begin
            @(posedge clk);
            e = !clk_half;
            @(negedge clk);
            #1;
            n++;
        end while (!e && n < 100);
    endtask

    task automatic wait_mult_ld(input string name);
        int n = 0;
        while (!mult_ld && n < 200) begin cyc(1); n++; end
        if (!mult_ld) check(name, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (grant != 2'b00 && n < 200) begin cyc(1); n++; end
        check(name, 64'(grant), 64'd0);
    endtask

    task automatic push_exp(input int p, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        if (p == 0) exp_q0.push_back(prod); else exp_q1.push_back(prod);
    endtask

    task automatic run_req(input int p, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk); #1;
        req_a[p] = a; req_b[p] = b; req_ld[p] = 1'b1;
        push_exp(p, a, b);
        while (!get_ok(p) && n < 400) begin cyc(1); n++; end
        if (!get_ok(p)) check($sformatf("ok%0d_timeout", p), 64'd0, 64'd1);
        cyc($urandom_range(0, 3));
        req_ld[p] = 1'b0;
        n = 0;
        while (get_ok(p) && n < 100) begin cyc(1); n++; end
        if (get_ok(p)) check($sformatf("ok%0d_stuck", p), 64'd1, 64'd0);
    endtask

    task automatic run_round(input bit [1:0] who);
        int first_exp;
        logic [7:0] a0, b0, a1, b1;
        a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
        a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
        first_exp = (who == 2'b11) ? ((rr_last == 1) ? 0 : 1) : (who[1] ? 1 : 0);
        grant_log.delete();
        fork
            if (who[0]) run_req(0, a0, b0);
            if (who[1]) run_req(1, a1, b1);
        join
        wait_idle("round_idle");
        if (grant_log.size() == 0) check("rr_first_missing", 64'd0, 64'd1);
        else check("rr_first", 64'(grant_log[0]), 64'(first_exp));
        if (who == 2'b11) begin
            if (grant_log.size() < 2) check("rr_second_missing", 64'd0, 64'd1);
            else check("rr_second", 64'(grant_log[1]), 64'(1 - first_exp));
        end
        rr_last = (who == 2'b11) ? 1 - first_exp : first_exp;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        rr_last = 1;
    endtask

    task automatic basic_txn(input int mode);
        int n;
        half_mode = mode;
        mdl_delay = 4;
        cyc(2);
        req_a[0] = 8'h10; req_b[0] = 8'h20; req_ld[0] = 1'b1;
        exp_q0.push_back(16'h0200);
        n = 0;
        while (!mult_ld && n < 20) begin step(); n++; end
        check("ld_latency", 64'(n), 64'd2);
        check("mult1", 64'(mult1), 64'h10);
        check("mult2", 64'(mult2), 64'h20);
        check("grant_busy", 64'(grant), 64'd1);
        n = 0;
        while (!mult_ok && n < 20) begin step(); n++; end
        check("mult_ok_seen", 64'(mult_ok), 64'd1);
        step();
        check("ok_latency", 64'(req0_ok), 64'd1);
        repeat (3) step();
        check("ok_held", 64'(req0_ok), 64'd1);
        req_ld[0] = 1'b0;
        step();
        check("ok_dropped", 64'(req0_ok), 64'd0);
        check("res_held", 64'(req0_res), 64'h0200);
        wait_idle("basic_idle");
        rr_last = 0;
        half_mode = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] snap;
        logic [15:0] res1_before;
        req_ld[0] = 1'b0; req_ld[1] = 1'b0;
        req_a[0] = 8'h0; req_b[0] = 8'h0; req_a[1] = 8'h0; req_b[1] = 8'h0;
        cyc(2);
        check("rst_outs", {mult_ld, grant, mult1, mult2, req0_ok, req1_ok, timeout_err},
              64'd0);
        check("rst_res", {req0_res, req1_res}, 64'd0);
        reset = 1'b1;
        cyc(2);

        basic_txn(0);
        basic_txn(1);

        // Simultaneous pairs after reset: req0 first both times.
        do_reset();
        run_round(2'b11);
        run_round(2'b11);

        // Multiplier still signalling done: no grant may be issued.
        force_ok = 1'b1;
        req_a[0] = 8'h03; req_b[0] = 8'h05; req_ld[0] = 1'b1;
        repeat (5) step();
        check("no_grant_while_ok", 64'(grant), 64'd0);
        exp_q0.push_back(16'd15);
        force_ok = 1'b0;
        begin
            int n = 0;
            while (!req0_ok && n < 100) begin cyc(1); n++; end
        end
        check("served_after_ok_low", 64'(req0_ok), 64'd1);
        req_ld[0] = 1'b0;
        wait_idle("idle_after_ok_low");
        rr_last = 0;

        // Requester 1 abandons its request during WAIT.
        mdl_delay = 6;
        res1_before = req1_res;
        req_a[1] = 8'h77; req_b[1] = 8'h11; req_ld[1] = 1'b1;
        wait_mult_ld("abort_ld");
        step();
        req_ld[1] = 1'b0;
        begin
            int n = 0;
            while (!mult_ok && n < 100) begin cyc(1); n++; end
        end
        wait_idle("abort_idle");
        check("abort_ok1", 64'(req1_ok), 64'd0);
        check("abort_res1", 64'(req1_res), 64'(res1_before));
        rr_last = 1;

        // Multiplier never answers; clk_half held high part-way through.
        mdl_never = 1'b1;
        req_a[0] = 8'h21; req_b[0] = 8'h42; req_ld[0] = 1'b1;
        wait_mult_ld("tmo_ld");
        ld_high_edges = 0;
        half_mode = 2;
        cyc(2);
        snap = {req0_res, req1_res, mult_ld, grant, mult1, mult2, req0_ok, req1_ok, timeout_err};
        cyc(10);
        check("hold_frozen", {req0_res, req1_res, mult_ld, grant, mult1, mult2, req0_ok, req1_ok, timeout_err}, snap);
        half_mode = 0;
        begin
            int n = 0;
            while (!timeout_err && n < 100) begin cyc(1); n++; end
        end
        check("timeout_err", 64'(timeout_err), 64'd1);
        check("timeout_edges", 64'(ld_high_edges), 64'(TMO));
        check("timeout_ld_low", 64'(mult_ld), 64'd0);
        check("timeout_no_ok", 64'(req0_ok), 64'd0);
        req_ld[0] = 1'b0;
        wait_idle("timeout_idle");
        rr_last = 0;
        mdl_never = 1'b0;
        mdl_delay = 2;
        run_round(2'b01);
        check("timeout_sticky", 64'(timeout_err), 64'd1);

        // Reset in WAIT abandons the transaction; held ld restarts cleanly.
        mdl_never = 1'b1;
        req_a[0] = 8'h0F; req_b[0] = 8'h0E; req_ld[0] = 1'b1;
        wait_mult_ld("rst_mid_ld");
        step();
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst_mid_outs", {mult_ld, grant, mult1, mult2, req0_ok, req1_ok, timeout_err},
              64'd0);
        check("rst_mid_res", {req0_res, req1_res}, 64'd0);
        cyc(2);
        mdl_never = 1'b0;
        exp_q0.push_back(16'd210);
        reset = 1'b1;
        rr_last = 1;
        begin
            int n = 0;
            while (!req0_ok && n < 100) begin cyc(1); n++; end
        end
        check("rst_fresh_ok", 64'(req0_ok), 64'd1);
        req_ld[0] = 1'b0;
        wait_idle("rst_fresh_idle");
        rr_last = 0;

        // Randomised rounds, mixed enable patterns and multiplier latencies.
        for (int i = 0; i < 20; i++) begin
            half_mode = $urandom_range(0, 1);
            mdl_delay = $urandom_range(1, 6);
            run_round(2'($urandom_range(1, 3)));
        end
        half_mode = 0;

        cyc(4);
        check("exp_q0_drained", 64'(exp_q0.size()), 64'd0);
        check("exp_q1_drained", 64'(exp_q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
